pixel_readback_buffer: RTL
==========================

Name: pixel_readback_buffer

Overview:
- Sink-side counterpart of the pixel writer stream (x, y, colour, plot) driven into the VGA adapter.
- Snoops the same stream in parallel with the adapter and keeps a shadow 160x120 colour framebuffer.
- Serves single-pixel read requests, so game logic (collision checks, hit tests) can read back what was drawn.
- Also clears itself to a known colour and counts dropped writes.

Parameters:
- WIDTH, 160, framebuffer columns; x >= WIDTH is out of range.
- HEIGHT, 120, framebuffer rows; y >= HEIGHT is out of range.
- COLOUR_BITS, 3, bits per stored pixel.
- CLEAR_COLOUR, 3'b000, value written by the clear sweep.

Ports:
- clock  input  1  system clock (50 MHz)
- reset  input  1  synchronous, active-high reset
- x  input  8  pixel column of the write stream
- y  input  7  pixel row of the write stream
- colour  input  COLOUR_BITS  pixel colour of the write stream
- plot  input  1  write strobe; one pixel per cycle while high
- clear_req  input  1  one-cycle pulse; starts (or restarts) a clear sweep
- rd_req  input  1  read request; held high until accepted
- rd_x  input  8  read column, sampled on accept
- rd_y  input  7  read row, sampled on accept
- rd_ready  output  1  high when a request would be accepted this cycle
- rd_valid  output  1  one-cycle pulse; rd_colour is valid
- rd_colour  output  COLOUR_BITS  read result, held until the next rd_valid
- busy  output  1  high during a clear sweep
- drop_count  output  8  saturating count of rejected plot writes

Behaviour:
- Address mapping:
  - addr = y*WIDTH + x, 15 bits.
  - For WIDTH=160, implement as (y<<7)+(y<<5)+x; no multiplier.
- Storage:
  - WIDTH*HEIGHT x COLOUR_BITS RAM with one synchronous write port and one synchronous read port.
  - Read data appears 1 cycle after the read address is registered.
- FSM states:
  - CLEAR: sweep counter 0..WIDTH*HEIGHT-1; write CLEAR_COLOUR at one address per cycle; busy=1; rd_ready=0. On the final address, go to IDLE next cycle. A full sweep is 19200 cycles.
  - IDLE: rd_ready=1. When rd_req=1, latch rd_x/rd_y and go to READ.
  - READ: present the registered address to RAM; rd_ready=0; go to RESP.
  - RESP: register RAM output into rd_colour; rd_valid=1 for exactly this cycle; rd_ready=0; go to IDLE.
- Read timing:
  - Latency from accept (rd_req & rd_ready at edge N) to rd_valid is edge N+2.
  - Back-to-back reads achieve one result every 3 cycles.
- Out-of-range reads:
  - rd_x >= WIDTH or rd_y >= HEIGHT still completes the handshake.
  - rd_colour = CLEAR_COLOUR; RAM is not accessed.
- Plot writes:
  - A plot in IDLE/READ/RESP with x, y in range writes RAM at addr the same cycle.
  - A plot is dropped, and drop_count increments, when it is out of range or occurs while busy.
  - drop_count saturates at 255.
- Read-during-write:
  - If the address used in the READ cycle equals the plot address written in that same cycle, rd_colour returns the new colour (write-first bypass).
- clear_req:
  - In any state, it forces CLEAR with the counter reset to 0.
  - An in-flight read is aborted: no rd_valid is issued.
  - drop_count is not cleared.
- reset:
  - rd_valid=0, rd_colour=CLEAR_COLOUR, drop_count=0, busy=1, rd_ready=0; state CLEAR, counter 0.
  - Reset asserted mid-sweep or mid-read restarts the sweep from address 0.
- Simultaneous events:
  - reset has priority over clear_req.
  - clear_req has priority over rd_req.
  - A plot and a read in the same cycle are both serviced.

Test Plan:
1. Release reset → busy=1 for exactly 19200 cycles, then rd_ready=1; reading (0,0) and (159,119) returns 3'b000.
2. After the clear, plot (10,20)=3'b101 → rd_req (10,20) accepted at edge N; rd_valid at edge N+2 with rd_colour=3'b101; reading (11,20) returns 3'b000.
3. plot (10,20)=3'b011 in the same cycle as the READ state for (10,20) → rd_colour=3'b011 (bypass).
4. Plots at (160,0), (0,120) and three plots while busy → drop_count=5, and RAM is unchanged at (0,0).
5. clear_req while in READ → no rd_valid pulse, busy=1 for 19200 cycles; a subsequent read of (10,20) returns 3'b000.
6. 300 out-of-range plots → drop_count saturates at 255; reset → drop_count=0.

Source files
------------

// File: rtl/pixel_readback_buffer_if.sv
// Pixel writer stream plus single-pixel readback handshake shared by the
// drawing logic (master) and the shadow framebuffer (slave).
interface pixel_readback_buffer_if #(
    parameter int COLOUR_BITS = 3
) ();
    logic [7:0]             x;
    logic [6:0]             y;
    logic [COLOUR_BITS-1:0] colour;
    logic                   plot;
    logic                   clear_req;
    logic                   rd_req;
    logic [7:0]             rd_x;
    logic [6:0]             rd_y;
    logic                   rd_ready;
    logic                   rd_valid;
    logic [COLOUR_BITS-1:0] rd_colour;
    logic                   busy;
    logic [7:0]             drop_count;

    modport master (
        output x, y, colour, plot, clear_req, rd_req, rd_x, rd_y,
        input  rd_ready, rd_valid, rd_colour, busy, drop_count
    );

    modport slave (
        input  x, y, colour, plot, clear_req, rd_req, rd_x, rd_y,
        output rd_ready, rd_valid, rd_colour, busy, drop_count
    );
endinterface

// File: rtl/pixel_readback_buffer.sv
// Shadow 160x120 framebuffer snooping the pixel writer stream; serves
// single-pixel reads, self-clears on reset/clear_req and counts dropped plots.
module pixel_readback_buffer #(
    parameter int                     WIDTH        = 160,
    parameter int                     HEIGHT       = 120,
    parameter int                     COLOUR_BITS  = 3,
    parameter logic [COLOUR_BITS-1:0] CLEAR_COLOUR = 3'b000
) (
    input logic                    clock,
    input logic                    reset,
    pixel_readback_buffer_if.slave bus
);
    localparam int         DEPTH     = WIDTH * HEIGHT;
    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
    localparam logic [7:0]  X_LIMIT   = 8'(WIDTH);
    localparam logic [6:0]  Y_LIMIT   = 7'(HEIGHT);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [14:0]            clr_cnt_q, clr_cnt_d;
    logic [14:0]            rd_addr_q, rd_addr_d;
    logic                   rd_oor_q, rd_oor_d;
    logic                   rd_byp_q, rd_byp_d;
    logic [COLOUR_BITS-1:0] byp_colour_q, byp_colour_d;
    logic [7:0]             drop_count_q, drop_count_d;
    logic                   busy_q, busy_d;
    logic                   rd_ready_q, rd_ready_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [COLOUR_BITS-1:0] rd_colour_q, rd_colour_d;
    logic [COLOUR_BITS-1:0] ram_rdata_q;

    logic                   plot_in_range_s;
    logic                   req_in_range_s;
    logic                   wr_en_s;
    logic [14:0]            wr_addr_s;
    logic [COLOUR_BITS-1:0] wr_data_s;
    logic                   rd_en_s;

    logic [COLOUR_BITS-1:0] pixel_mem [DEPTH];

    // y*160 + x built from shifts: y*128 + y*32 + x.
    function automatic logic [14:0] pixel_addr(input logic [7:0] px, input logic [6:0] py);
        return {1'b0, py, 7'b0000000} + {3'b000, py, 5'b00000} + {7'b0000000, px};
    endfunction

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_CLEAR;
        else       state_q <= state_d;
    end

    // FSM next state and clear-sweep counter; clear_req overrides everything.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (bus.clear_req) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = 15'd0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d   = ST_IDLE;
                        clr_cnt_d = 15'd0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 15'd1;
                    end
                end
                ST_IDLE: begin
                    if (bus.rd_req) state_d = ST_READ;
                    else            state_d = ST_IDLE;
                end
                ST_READ: state_d = ST_RESP;
                ST_RESP: state_d = ST_IDLE;
                default: state_d = ST_CLEAR;
            endcase
        end
    end

    // Write-port arbitration, drop counting, read address capture and bypass detect.
    always_comb begin
        plot_in_range_s = (bus.x < X_LIMIT) && (bus.y < Y_LIMIT);
        req_in_range_s  = (bus.rd_x < X_LIMIT) && (bus.rd_y < Y_LIMIT);

        if (state_q == ST_CLEAR) begin
            wr_en_s   = !reset;
            wr_addr_s = clr_cnt_q;
            wr_data_s = CLEAR_COLOUR;
        end else begin
            wr_en_s   = !reset && bus.plot && plot_in_range_s;
            wr_addr_s = pixel_addr(bus.x, bus.y);
            wr_data_s = bus.colour;
        end

        if (bus.plot && ((state_q == ST_CLEAR) || !plot_in_range_s) && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end else begin
            drop_count_d = drop_count_q;
        end

        if ((state_q == ST_IDLE) && bus.rd_req) begin
            rd_addr_d = pixel_addr(bus.rd_x, bus.rd_y);
            rd_oor_d  = !req_in_range_s;
        end else begin
            rd_addr_d = rd_addr_q;
            rd_oor_d  = rd_oor_q;
        end

        rd_en_s = (state_q == ST_READ) && !rd_oor_q;

        // The RAM returns old data on a same-cycle collision, so remember the new value.
        if (state_q == ST_READ) begin
            rd_byp_d     = wr_en_s && (wr_addr_s == rd_addr_q);
            byp_colour_d = wr_data_s;
        end else begin
            rd_byp_d     = rd_byp_q;
            byp_colour_d = byp_colour_q;
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        busy_d     = (state_d == ST_CLEAR);
        rd_ready_d = (state_d == ST_IDLE);
        rd_valid_d = (state_q == ST_RESP) && !bus.clear_req;
        if (rd_valid_d) begin
            rd_colour_d = rd_oor_q ? CLEAR_COLOUR : (rd_byp_q ? byp_colour_q : ram_rdata_q);
        end else begin
            rd_colour_d = rd_colour_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            clr_cnt_q    <= 15'd0;
            rd_addr_q    <= 15'd0;
            rd_oor_q     <= 1'b0;
            rd_byp_q     <= 1'b0;
            byp_colour_q <= CLEAR_COLOUR;
            drop_count_q <= 8'd0;
            busy_q       <= 1'b1;
            rd_ready_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_colour_q  <= CLEAR_COLOUR;
        end else begin
            clr_cnt_q    <= clr_cnt_d;
            rd_addr_q    <= rd_addr_d;
            rd_oor_q     <= rd_oor_d;
            rd_byp_q     <= rd_byp_d;
            byp_colour_q <= byp_colour_d;
            drop_count_q <= drop_count_d;
            busy_q       <= busy_d;
            rd_ready_q   <= rd_ready_d;
            rd_valid_q   <= rd_valid_d;
            rd_colour_q  <= rd_colour_d;
        end
    end

    // Framebuffer RAM: one synchronous write port, one synchronous read port.
    always_ff @(posedge clock) begin
        if (wr_en_s) pixel_mem[wr_addr_s] <= wr_data_s;
        if (rd_en_s) ram_rdata_q <= pixel_mem[rd_addr_q];
    end

    assign bus.rd_ready   = rd_ready_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_colour  = rd_colour_q;
    assign bus.busy       = busy_q;
    assign bus.drop_count = drop_count_q;
endmodule
